seq_subtractor_64_bit: RTL and testbench

Multi-cycle 64-bit unsigned/two's-complement subtractor. It computes diff = a - b - b_in one SLICE-bit chunk per clock, propagating a registered borrow between chunks, LSB chunk first. It is the inverse datapath of the team's ripple-carry adder chain and sits beside it in the ALU. It trades latency for a short critical path and uses a start/busy/done handshake.

---
 rtl/seq_subtractor_64_bit.sv | 115 +++++++++++
 tb/tb_seq_subtractor_64_bit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor_64_bit.sv
// Multi-cycle subtractor: diff = a - b - b_in, computed one SLICE-bit chunk
// per clock (LSB chunk first) with a registered borrow between chunks.
// The chain runs in "carry" form: a + ~b + c, where c = ~borrow.
module seq_subtractor_64_bit #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             c_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] diff_reg;
   logic             b_out_reg;
   logic             overflow_reg;
   logic             zero_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [SLICE-1:0] a_sl [N];
   logic [SLICE-1:0] b_sl [N];
   logic [SLICE:0]   sum_next;
   logic [WIDTH-1:0] diff_next;

   // Split the latched operands into slices, and build the full diff as it
   // will look once the current slice result is merged in.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_slice
         assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
         assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
         assign diff_next[gi*SLICE +: SLICE] =
            (cnt_reg == CW'(gi)) ? sum_next[SLICE-1:0] : diff_reg[gi*SLICE +: SLICE];
      end
   endgenerate

   // One slice of a + ~b + carry; the MSB is the carry (inverse borrow) out.
   assign sum_next = {1'b0, a_sl[cnt_reg]} + {1'b0, ~b_sl[cnt_reg]}
                   + {{SLICE{1'b0}}, c_reg};

   // Control FSM and datapath registers; all outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         c_reg        <= 1'b0;
         cnt_reg      <= '0;
         diff_reg     <= '0;
         b_out_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  c_reg     <= ~b_in;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end else begin
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               diff_reg <= diff_next;
               c_reg    <= sum_next[SLICE];
               cnt_reg  <= cnt_reg + 1'b1;
               if (cnt_reg == LAST) begin
                  b_out_reg    <= ~sum_next[SLICE];
                  overflow_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                  (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
                  zero_reg     <= (diff_next == '0);
                  done_reg     <= 1'b1;
                  busy_reg     <= 1'b0;
                  state_reg    <= DONE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign diff     = diff_reg;
   assign b_out    = b_out_reg;
   assign overflow = overflow_reg;
   assign zero     = zero_reg;

endmodule

// File: tb/tb_seq_subtractor_64_bit.sv
// Self-checking bench for seq_subtractor_64_bit: directed vector table,
// handshake / reset sequences, and random operands against a small model.
module tb_seq_subtractor_64_bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] a;
   logic [63:0] b;
   logic        b_in;
   logic        busy;
   logic        done;
   logic [63:0] diff;
   logic        b_out;
   logic        overflow;
   logic        zero;

   int tests  = 0;
   int errors = 0;

   seq_subtractor_64_bit dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .b_out    (b_out),
      .overflow (overflow),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        b_in;
      logic [63:0] diff;
      logic        b_out;
      logic        ov;
      logic        zero;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation from a negedge; return latency (edges after accept
   // until done is seen) and number of busy cycles seen before done.
   task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tbin,
                         output int lat, output int busy_cnt);
      @(negedge clk);
      a = ta; b = tb_; b_in = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, bc, pulses;
      logic [64:0]  full;
      logic [63:0]  ra, rb, ed;
      logic         rbin, eov;

      vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{64'h0000_0000_0001_0000, 64'd0, 1'b1, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

      // Reset state
      rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_diff", diff, 64'd0);
      chk("rst_flags", {61'd0, b_out, overflow, zero}, 64'd0);

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].b_in, lat, bc);
         $display("[TB] vec %0d a=%h b=%h bin=%0d -> diff=%h bo=%0d ov=%0d z=%0d lat=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].b_in, diff, b_out, overflow, zero, lat);
         chk("vec_latency", 64'(lat), 64'd4);
         chk("vec_busy_cycles", 64'(bc), 64'd4);
         chk("vec_busy_at_done", {63'd0, busy}, 64'd0);
         chk("vec_diff", diff, vecs[i].diff);
         chk("vec_b_out", {63'd0, b_out}, {63'd0, vecs[i].b_out});
         chk("vec_overflow", {63'd0, overflow}, {63'd0, vecs[i].ov});
         chk("vec_zero", {63'd0, zero}, {63'd0, vecs[i].zero});
         @(negedge clk);
         chk("vec_done_pulse", {63'd0, done}, 64'd0);
      end

      // Handshake: start during RUN is ignored
      @(negedge clk);
      a = 64'd100; b = 64'd1; b_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 64'd7; b = 64'd7; b_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 2;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      $display("[TB] ignore-start: diff=%h lat=%0d", diff, lat);
      chk("hs_ignore_latency", 64'(lat), 64'd4);
      chk("hs_ignore_diff", diff, 64'd99);
      chk("hs_ignore_zero", {63'd0, zero}, 64'd0);

      // Back-to-back start in the DONE cycle
      a = 64'd10; b = 64'd4; b_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_done_drop", {63'd0, done}, 64'd0);
      chk("b2b_busy_rise", {63'd0, busy}, 64'd1);
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      $display("[TB] back-to-back: diff=%h lat=%0d", diff, lat);
      chk("b2b_latency", 64'(lat), 64'd4);
      chk("b2b_diff", diff, 64'd6);

      // Reset mid-RUN: prior result has b_out/zero-style flags set first
      run_op(64'd0, 64'd1, 1'b0, lat, bc);
      chk("pre_rst_b_out", {63'd0, b_out}, 64'd1);
      @(negedge clk);
      a = 64'd5; b = 64'd3; b_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset mid-run: busy=%0d done=%0d diff=%h", busy, done, diff);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_done", {63'd0, done}, 64'd0);
      chk("mid_rst_diff", diff, 64'd0);
      chk("mid_rst_flags", {61'd0, b_out, overflow, zero}, 64'd0);
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("mid_rst_no_done", 64'(pulses), 64'd0);
      run_op(64'd5, 64'd3, 1'b0, lat, bc);
      $display("[TB] after reset: diff=%h lat=%0d", diff, lat);
      chk("post_rst_latency", 64'(lat), 64'd4);
      chk("post_rst_diff", diff, 64'd2);

      // Random operands against a reference model
      for (int i = 0; i < 1000; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rbin = 1'($urandom_range(0, 1));
         if (i % 10 == 0) rb = ra;
         full = {1'b0, ra} - {1'b0, rb} - {64'd0, rbin};
         ed = full[63:0];
         eov = (ra[63] != rb[63]) && (ed[63] != ra[63]);
         run_op(ra, rb, rbin, lat, bc);
         $display("[TB] rnd %0d a=%h b=%h bin=%0d diff=%h", i, ra, rb, rbin, diff);
         chk("rnd_latency", 64'(lat), 64'd4);
         chk("rnd_diff", diff, ed);
         chk("rnd_b_out", {63'd0, b_out}, {63'd0, full[64]});
         chk("rnd_overflow", {63'd0, overflow}, {63'd0, eov});
         chk("rnd_zero", {63'd0, zero}, {63'd0, (ed == 64'd0)});
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
